// File: rtl/timer_irq_periph_pkg.sv
// Shared constants for the timer peripheral: base address, register offsets
// and TCON bit positions, reused by the bus decoder and other peripherals.
package timer_irq_periph_pkg;

  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

  localparam logic [3:0] TH_OFF      = 4'h0;
  localparam logic [3:0] TL_OFF      = 4'h4;
  localparam logic [3:0] TCON_OFF    = 4'h8;
  localparam logic [3:0] SYSTICK_OFF = 4'hC;

  localparam int EN_BIT = 0;
  localparam int IE_BIT = 1;
  localparam int ST_BIT = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_SYSTICK
  } reg_sel_e;

endpackage

// File: rtl/timer_irq_periph_prescaler.sv
// Prescaler: emits a one-cycle tick every DIV enabled cycles; held at zero
// while disabled so counting always restarts from a clean phase.
module timer_prescaler #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || tick_o) cnt_d = '0;
    else                 cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_irq_periph.sv
// Memory-mapped timer: TL counts up on prescaler ticks, reloads from TH on
// overflow and latches ST, which holds irq until software clears it.
module timer_irq_periph
  import timer_irq_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = PERIPH_BASE,
  parameter int unsigned DIV       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [31:0] systick_q;

  reg_sel_e sel;
  logic     hit;
  logic [3:0] off;
  logic     tick, ovf;
  logic     wr_th, wr_tl, wr_tcon;
  logic     unused_addr_lsbs;

  // Byte lanes are irrelevant: every register is a full word.
  assign unused_addr_lsbs = ^addr[1:0];
  assign hit = (addr[31:4] == BASE_ADDR[31:4]);
  assign off = {addr[3:2], 2'b00};

  always_comb begin
    sel = SEL_NONE;
    if (hit) begin
      case (off)
        TH_OFF:      sel = SEL_TH;
        TL_OFF:      sel = SEL_TL;
        TCON_OFF:    sel = SEL_TCON;
        SYSTICK_OFF: sel = SEL_SYSTICK;
        default:     sel = SEL_NONE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      case (sel)
        SEL_TH:      rd_data = th_q;
        SEL_TL:      rd_data = tl_q;
        SEL_TCON:    rd_data = {29'd0, tcon_q};
        SEL_SYSTICK: rd_data = systick_q;
        default:     rd_data = '0;
      endcase
    end
  end

  assign wr_th   = wr_en && (sel == SEL_TH);
  assign wr_tl   = wr_en && (sel == SEL_TL);
  assign wr_tcon = wr_en && (sel == SEL_TCON);

  timer_prescaler #(.DIV(DIV)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en_i   (tcon_q[EN_BIT]),
    .tick_o (tick)
  );

  assign ovf = tick && (tl_q == 32'hFFFF_FFFF);

  // Bus writes override the counter; an overflow set of ST beats a clearing write.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (tick)    tl_d   = ovf ? th_q : tl_q + 32'd1;
    if (wr_th)   th_d   = wr_data;
    if (wr_tl)   tl_d   = wr_data;
    if (wr_tcon) tcon_d = wr_data[2:0];
    if (ovf && tcon_q[IE_BIT]) tcon_d[ST_BIT] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      systick_q <= systick_q + 32'd1;
    end
  end

  assign irq = tcon_q[IE_BIT] & tcon_q[ST_BIT];

endmodule

// File: tb/tb_timer_irq_periph.sv
// Directed bench for timer_irq_periph: one DIV=1 and one DIV=4 instance on a
// shared bus, with hand-computed expected register values.
module tb_timer_irq_periph;
  import timer_irq_periph_pkg::*;

  localparam logic [31:0] B = PERIPH_BASE;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        rd_en, wr_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data1, rd_data4;
  logic        irq1, irq4;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] tb_cyc;

  always #5 clk = ~clk;

  timer_irq_periph #(.BASE_ADDR(B), .DIV(1)) dut1 (
    .clk(clk), .reset(reset), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .wr_data(wr_data), .rd_data(rd_data1), .irq(irq1)
  );

  timer_irq_periph #(.BASE_ADDR(B), .DIV(4)) dut4 (
    .clk(clk), .reset(reset), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .wr_data(wr_data), .rd_data(rd_data4), .irq(irq4)
  );

  // Reference cycle count for SYSTICK expectations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tb_cyc <= '0;
    else       tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input bit use4, input logic [31:0] a,
                        input logic [31:0] exp);
    addr  = a;
    rd_en = 1'b1;
    #1;
    chk(tag, use4 ? rd_data4 : rd_data1, exp);
    rd_en = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr    = a;
    wr_data = d;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; addr = '0; rd_en = 1'b0; wr_en = 1'b0; wr_data = '0;
    step(2);
    rd_chk("rst_th", 0, B + 32'h0, 32'h0);
    rd_chk("rst_tl", 0, B + 32'h4, 32'h0);
    rd_chk("rst_tcon", 0, B + 32'h8, 32'h0);
    rd_chk("rst_systick", 0, B + 32'hC, 32'h0);
    chk("rst_irq", {31'd0, irq1}, 32'd0);
    @(negedge clk) reset = 1'b0;
    step(1);
    rd_chk("systick_first", 0, B + 32'hC, tb_cyc);

    // Overflow with interrupt, DIV=1
    bus_wr(B + 32'h0, 32'hFFFF_FFFD);
    bus_wr(B + 32'h4, 32'hFFFF_FFFE);
    bus_wr(B + 32'h8, 32'h3);
    rd_chk("ovf_tl_start", 0, B + 32'h4, 32'hFFFF_FFFE);
    step(1);
    rd_chk("ovf_tl_max", 0, B + 32'h4, 32'hFFFF_FFFF);
    chk("ovf_irq_pre", {31'd0, irq1}, 32'd0);
    step(1);
    rd_chk("ovf_tl_reload", 0, B + 32'h4, 32'hFFFF_FFFD);
    rd_chk("ovf_tcon_st", 0, B + 32'h8, 32'h7);
    chk("ovf_irq", {31'd0, irq1}, 32'd1);
    step(3);
    rd_chk("ovf_tl_wrap3", 0, B + 32'h4, 32'hFFFF_FFFD);
    chk("ovf_irq_hold", {31'd0, irq1}, 32'd1);

    // Clearing ST on an overflow cycle must lose to the set
    step(2);
    rd_chk("race_tl_max", 0, B + 32'h4, 32'hFFFF_FFFF);
    bus_wr(B + 32'h8, 32'h3);
    rd_chk("race_tcon", 0, B + 32'h8, 32'h7);
    chk("race_irq", {31'd0, irq1}, 32'd1);
    bus_wr(B + 32'h8, 32'h3);
    rd_chk("clr_tcon", 0, B + 32'h8, 32'h3);
    chk("clr_irq", {31'd0, irq1}, 32'd0);

    // Software-forced interrupt; tick on the EN=0 write still applies
    bus_wr(B + 32'h8, 32'h6);
    chk("force_irq", {31'd0, irq1}, 32'd1);
    step(2);
    rd_chk("force_tl_frozen", 0, B + 32'h4, 32'hFFFF_FFFF);

    // IE=0: reload without status
    bus_wr(B + 32'h8, 32'h0);
    chk("force_clr_irq", {31'd0, irq1}, 32'd0);
    bus_wr(B + 32'h0, 32'h0000_0100);
    bus_wr(B + 32'h4, 32'hFFFF_FFFF);
    bus_wr(B + 32'h8, 32'h1);
    step(1);
    rd_chk("noie_tl_reload", 0, B + 32'h4, 32'h0000_0100);
    rd_chk("noie_tcon", 0, B + 32'h8, 32'h1);
    rd_chk("noie_th", 0, B + 32'h0, 32'h0000_0100);
    chk("noie_irq", {31'd0, irq1}, 32'd0);

    // Prescale DIV=4
    bus_wr(B + 32'h8, 32'h0);
    bus_wr(B + 32'h4, 32'h0);
    bus_wr(B + 32'h8, 32'h1);
    step(3);
    rd_chk("div4_tl_c3", 1, B + 32'h4, 32'h0);
    step(1);
    rd_chk("div4_tl_c4", 1, B + 32'h4, 32'h1);
    step(8);
    rd_chk("div4_tl_c12", 1, B + 32'h4, 32'h3);
    rd_chk("div1_tl_c12", 0, B + 32'h4, 32'd12);
    bus_wr(B + 32'h8, 32'h0);
    step(5);
    rd_chk("div4_tl_frozen", 1, B + 32'h4, 32'h3);
    rd_chk("div4_systick", 1, B + 32'hC, tb_cyc);

    // Bus decode checks
    bus_wr(B + 32'hC, 32'hDEAD_BEEF);
    rd_chk("systick_wr_ignored", 0, B + 32'hC, tb_cyc);
    bus_wr(B + 32'h10, 32'h55);
    rd_chk("rd_off10", 0, B + 32'h10, 32'h0);
    rd_chk("rd_low_addr", 0, 32'h0000_0004, 32'h0);
    rd_chk("rd_byte_lane", 0, B + 32'h6, 32'd13);
    addr = B + 32'h4; rd_en = 1'b0; #1;
    chk("rd_en_low", rd_data1, 32'h0);

    // TL write coinciding with a tick
    bus_wr(B + 32'h8, 32'h1);
    bus_wr(B + 32'h4, 32'h0000_1234);
    rd_chk("tlwr_tick", 0, B + 32'h4, 32'h0000_1234);
    step(1);
    rd_chk("tlwr_next", 0, B + 32'h4, 32'h0000_1235);

    // Asynchronous reset mid-count
    bus_wr(B + 32'h4, 32'h5);
    bus_wr(B + 32'h8, 32'h7);
    chk("pre_rst_irq", {31'd0, irq1}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_irq", {31'd0, irq1}, 32'd0);
    rd_chk("mid_rst_th", 0, B + 32'h0, 32'h0);
    rd_chk("mid_rst_tl", 0, B + 32'h4, 32'h0);
    rd_chk("mid_rst_tcon", 0, B + 32'h8, 32'h0);
    rd_chk("mid_rst_systick", 0, B + 32'hC, 32'h0);
    @(negedge clk) reset = 1'b0;
    step(1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
